// File: rtl/iso14443a_tag_rx_decoder.sv
// ISO14443-A tag response decoder: majority-votes subcarrier samples into Manchester
// half-bits, then handles SOF, LSB-first bytes, odd parity, collisions and EOF.
module iso14443a_tag_rx_decoder #(
    parameter int unsigned HALF_SAMPLES = 4,
    parameter int unsigned MAJ_THRESH   = 2
) (
    input  logic       ck_1356meg,
    input  logic       nreset,
    input  logic       enable,
    input  logic       mod_bit,
    input  logic       mod_bit_valid,
    output logic [7:0] rx_byte,
    output logic       rx_byte_valid,
    output logic       rx_parity_err,
    output logic       rx_collision,
    output logic       frame_start,
    output logic       frame_end,
    output logic [2:0] frame_bits_last,
    output logic       busy
);

    localparam int unsigned SW   = (HALF_SAMPLES > 1) ? $clog2(HALF_SAMPLES) : 1;
    localparam int unsigned MW   = $clog2(HALF_SAMPLES + 1);
    localparam int unsigned LAST = HALF_SAMPLES - 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SOF,
        S_DATA,
        S_EOF
    } state_t;

    state_t        state;
    logic [SW-1:0] samp_cnt;
    logic [MW-1:0] mod_cnt;
    logic          half_sel;
    logic          first_half;
    logic [3:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          coll;

    logic [MW-1:0] mod_sum_c;
    logic          half_end_c;
    logic          half_mod_c;
    logic          pair_coll_c;
    logic          pair_eof_c;

    // Half-bit vote and pair classification; the decoded bit always equals the first half.
    always_comb begin
        mod_sum_c   = MW'(mod_cnt + MW'(mod_bit));
        half_end_c  = mod_bit_valid && (samp_cnt == SW'(LAST));
        half_mod_c  = (mod_sum_c >= MW'(MAJ_THRESH));
        pair_coll_c = first_half && half_mod_c;
        pair_eof_c  = !first_half && !half_mod_c;
    end

    always_ff @(posedge ck_1356meg) begin
        if (!nreset || !enable) begin
            state           <= S_IDLE;
            samp_cnt        <= '0;
            mod_cnt         <= '0;
            half_sel        <= 1'b0;
            first_half      <= 1'b0;
            bit_cnt         <= '0;
            shreg           <= '0;
            coll            <= 1'b0;
            rx_byte         <= '0;
            rx_byte_valid   <= 1'b0;
            rx_parity_err   <= 1'b0;
            rx_collision    <= 1'b0;
            frame_start     <= 1'b0;
            frame_end       <= 1'b0;
            frame_bits_last <= '0;
            busy            <= 1'b0;
        end else begin
            rx_byte_valid <= 1'b0;
            frame_start   <= 1'b0;
            frame_end     <= 1'b0;

            case (state)
                S_IDLE: begin
                    // First modulated sample is sample 0 of SOF half 1 and fixes the phase.
                    if (mod_bit_valid && mod_bit) begin
                        state    <= S_SOF;
                        busy     <= 1'b1;
                        samp_cnt <= SW'(1);
                        mod_cnt  <= MW'(1);
                        half_sel <= 1'b0;
                    end
                end

                S_SOF, S_DATA: begin
                    if (mod_bit_valid && !half_end_c) begin
                        samp_cnt <= SW'(samp_cnt + SW'(1));
                        mod_cnt  <= mod_sum_c;
                    end else if (half_end_c) begin
                        samp_cnt <= '0;
                        mod_cnt  <= '0;
                        half_sel <= !half_sel;
                        if (!half_sel) begin
                            first_half <= half_mod_c;
                        end else if (state == S_SOF) begin
                            if (first_half && !half_mod_c) begin
                                state       <= S_DATA;
                                frame_start <= 1'b1;
                                bit_cnt     <= '0;
                                shreg       <= '0;
                                coll        <= 1'b0;
                            end else begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                            end
                        end else if (pair_eof_c) begin
                            state     <= S_EOF;
                            frame_end <= 1'b1;
                            if (bit_cnt == 4'd0) begin
                                frame_bits_last <= '0;
                            end else begin
                                rx_byte_valid   <= 1'b1;
                                rx_byte         <= shreg;
                                rx_collision    <= coll;
                                rx_parity_err   <= (bit_cnt == 4'd8);
                                frame_bits_last <= bit_cnt[2:0];
                            end
                        end else if (bit_cnt == 4'd8) begin
                            // Parity slot: odd parity over data plus parity bit.
                            rx_byte_valid   <= 1'b1;
                            rx_byte         <= shreg;
                            rx_parity_err   <= !((^shreg) ^ first_half);
                            rx_collision    <= coll || pair_coll_c;
                            frame_bits_last <= '0;
                            bit_cnt         <= '0;
                            shreg           <= '0;
                            coll            <= 1'b0;
                        end else begin
                            shreg[bit_cnt[2:0]] <= first_half;
                            bit_cnt             <= 4'(bit_cnt + 4'd1);
                            coll                <= coll || pair_coll_c;
                        end
                    end
                end

                S_EOF: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iso14443a_tag_rx_decoder.sv
// Directed bench for iso14443a_tag_rx_decoder: Manchester frames built from
// 8-sample bit patterns, strobes captured by a monitor and compared to hand values.
module tb_iso14443a_tag_rx_decoder;

    logic       ck_1356meg = 1'b0;
    logic       nreset = 1'b0;
    logic       enable = 1'b0;
    logic       mod_bit = 1'b0;
    logic       mod_bit_valid = 1'b0;
    logic [7:0] rx_byte;
    logic       rx_byte_valid;
    logic       rx_parity_err;
    logic       rx_collision;
    logic       frame_start;
    logic       frame_end;
    logic [2:0] frame_bits_last;
    logic       busy;

    iso14443a_tag_rx_decoder dut (
        .ck_1356meg      (ck_1356meg),
        .nreset          (nreset),
        .enable          (enable),
        .mod_bit         (mod_bit),
        .mod_bit_valid   (mod_bit_valid),
        .rx_byte         (rx_byte),
        .rx_byte_valid   (rx_byte_valid),
        .rx_parity_err   (rx_parity_err),
        .rx_collision    (rx_collision),
        .frame_start     (frame_start),
        .frame_end       (frame_end),
        .frame_bits_last (frame_bits_last),
        .busy            (busy)
    );

    always #5 ck_1356meg = !ck_1356meg;

    int n_vec = 0;
    int n_err = 0;

    // Strobe monitor, sampled 1 time unit after each rising edge.
    int         n_fs, n_fe, n_bv, n_bv_fe, n_bv_unaligned, n_busy;
    logic [7:0] last_byte;
    logic       last_perr, last_coll;
    logic [2:0] last_fbl;

    always @(posedge ck_1356meg) begin
        #1;
        if (frame_start) n_fs++;
        if (busy) n_busy++;
        if (frame_end) begin
            n_fe++;
            last_fbl = frame_bits_last;
        end
        if (rx_byte_valid) begin
            n_bv++;
            if (frame_end) n_bv_fe++;
            // Full-byte strobes must follow the closing sample by exactly one cycle.
            if (!mod_bit_valid) n_bv_unaligned++;
            last_byte = rx_byte;
            last_perr = rx_parity_err;
            last_coll = rx_collision;
        end
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    task automatic clr_mon();
        n_fs = 0; n_fe = 0; n_bv = 0; n_bv_fe = 0; n_bv_unaligned = 0; n_busy = 0;
        last_byte = 8'h00; last_perr = 1'b0; last_coll = 1'b0; last_fbl = 3'd0;
    endtask

    // One sample per 16 clocks, driven on the falling edge.
    task automatic send_sample(input logic b);
        @(negedge ck_1356meg);
        mod_bit = b;
        mod_bit_valid = 1'b1;
        @(negedge ck_1356meg);
        mod_bit_valid = 1'b0;
        mod_bit = 1'b0;
        repeat (14) @(negedge ck_1356meg);
    endtask

    // 8 samples, leftmost (MSB) first.
    task automatic send_pat(input logic [7:0] pat);
        for (int i = 7; i >= 0; i--) send_sample(pat[i]);
    endtask

    task automatic send_bit(input logic b);
        send_pat(b ? 8'hF0 : 8'h0F);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic p);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(p);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge ck_1356meg);
    endtask

    initial begin
        clr_mon();
        enable = 1'b1;
        nreset = 1'b0;
        idle(3);
        nreset = 1'b1;

        // Reset and idle with no modulation
        for (int i = 0; i < 64; i++) send_sample(1'b0);
        chk("idle_busy_seen", 8'(n_busy), 8'd0);
        chk("idle_fs", 8'(n_fs), 8'd0);
        chk("idle_fe", 8'(n_fe), 8'd0);
        chk("idle_bv", 8'(n_bv), 8'd0);
        chk("idle_rx_byte", rx_byte, 8'h00);
        chk("idle_flags", {3'b0, rx_parity_err, rx_collision, frame_bits_last}, 8'h00);

        // Single byte 0x04, correct parity
        clr_mon();
        send_pat(8'hF0);
        send_byte(8'h04, 1'b0);
        send_pat(8'h00);
        idle(8);
        chk("b04_fs", 8'(n_fs), 8'd1);
        chk("b04_bv", 8'(n_bv), 8'd1);
        chk("b04_byte", last_byte, 8'h04);
        chk("b04_perr", 8'(last_perr), 8'd0);
        chk("b04_coll", 8'(last_coll), 8'd0);
        chk("b04_fe", 8'(n_fe), 8'd1);
        chk("b04_fbl", 8'(last_fbl), 8'd0);
        chk("b04_bv_with_fe", 8'(n_bv_fe), 8'd0);
        chk("b04_strobe_timing", 8'(n_bv_unaligned), 8'd0);
        chk("b04_busy_after", 8'(busy), 8'd0);

        // Same byte with wrong parity
        clr_mon();
        send_pat(8'hF0);
        send_byte(8'h04, 1'b1);
        send_pat(8'h00);
        idle(8);
        chk("perr_byte", last_byte, 8'h04);
        chk("perr_flag", 8'(last_perr), 8'd1);
        chk("perr_fe", 8'(n_fe), 8'd1);

        // 4-bit NAK: 1,0,1,0
        clr_mon();
        send_pat(8'hF0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        send_pat(8'h00);
        idle(8);
        chk("nak_byte", last_byte, 8'h05);
        chk("nak_fbl", 8'(last_fbl), 8'd4);
        chk("nak_bv_with_fe", 8'(n_bv_fe), 8'd1);
        chk("nak_perr", 8'(last_perr), 8'd0);

        // Collision on bit 3 of 0x00, then a 1000/0000 noise pair that reads as EOF
        clr_mon();
        send_pat(8'hF0);
        for (int i = 0; i < 8; i++) begin
            if (i == 3) send_pat(8'hFF);
            else send_bit(1'b0);
        end
        send_bit(1'b0);
        send_pat(8'h80);
        idle(8);
        chk("coll_byte", last_byte, 8'h08);
        chk("coll_flag", 8'(last_coll), 8'd1);
        chk("coll_perr", 8'(last_perr), 8'd0);
        chk("coll_bv", 8'(n_bv), 8'd1);
        chk("coll_noise_eof", 8'(n_fe), 8'd1);
        chk("coll_fbl", 8'(last_fbl), 8'd0);

        // Invalid SOF
        clr_mon();
        send_pat(8'hFF);
        for (int i = 0; i < 16; i++) send_sample(1'b0);
        chk("badsof_fs", 8'(n_fs), 8'd0);
        chk("badsof_fe", 8'(n_fe), 8'd0);
        chk("badsof_busy", 8'(busy), 8'd0);

        // enable dropped mid-byte
        clr_mon();
        send_pat(8'hF0);
        send_bit(1'b1); send_bit(1'b1);
        send_sample(1'b1); send_sample(1'b1);
        chk("en_busy_before", 8'(busy), 8'd1);
        enable = 1'b0;
        @(posedge ck_1356meg); #1;
        chk("en_busy", 8'(busy), 8'd0);
        idle(4);
        enable = 1'b1;
        for (int i = 0; i < 24; i++) send_sample(1'b0);
        chk("en_strobes", 8'(n_fe + n_bv), 8'd0);
        chk("en_busy_after", 8'(busy), 8'd0);

        // nreset mid-frame
        clr_mon();
        send_pat(8'hF0);
        send_bit(1'b0);
        send_sample(1'b0); send_sample(1'b0);
        nreset = 1'b0;
        @(posedge ck_1356meg); #1;
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_rx_byte", rx_byte, 8'h00);
        idle(2);
        nreset = 1'b1;
        for (int i = 0; i < 24; i++) send_sample(1'b0);
        chk("rst_strobes", 8'(n_fe + n_bv), 8'd0);

        // Decoder still works after the aborts
        clr_mon();
        send_pat(8'hF0);
        send_byte(8'hA5, 1'b1);
        send_pat(8'h00);
        idle(8);
        chk("post_byte", last_byte, 8'hA5);
        chk("post_perr", 8'(last_perr), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
